minbd_buff_eject: RTL and testbench

Side-buffer ejection stage of the MinBD deflection router. It sits between the four link input registers and the permutation network. Each cycle it may divert one incoming flit into the side buffer (`sbuff`) under control of the 3-bit `cthulhu` select, and passes the other flits through unchanged. All outputs are registered.

---
 rtl/minbd_buff_eject_if.sv | 29 ++
 rtl/minbd_buff_eject.sv | 116 +++++++++++
 tb/tb_minbd_buff_eject.sv | 139 +++++++++++++
 3 files changed

// File: rtl/minbd_buff_eject_if.sv
// Link-side bundle of the MinBD side-buffer ejection stage: four lane flits and
// the ejection select in, four registered lanes and the side-buffer write out.
interface minbd_buff_eject_if #(
    parameter int unsigned FLIT_W = 11
);
    logic [FLIT_W-1:0] northad;
    logic [FLIT_W-1:0] southad;
    logic [FLIT_W-1:0] eastad;
    logic [FLIT_W-1:0] westad;
    logic [2:0]        cthulhu;

    logic [FLIT_W-1:0] nad;
    logic [FLIT_W-1:0] sad;
    logic [FLIT_W-1:0] ead;
    logic [FLIT_W-1:0] wad;
    logic [FLIT_W-1:0] sbuff;

    // Upstream side: link registers plus the ejection controller
    modport master (
        output northad, southad, eastad, westad, cthulhu,
        input  nad, sad, ead, wad, sbuff
    );

    // Ejection stage itself
    modport slave (
        input  northad, southad, eastad, westad, cthulhu,
        output nad, sad, ead, wad, sbuff
    );
endinterface

// File: rtl/minbd_buff_eject.sv
// MinBD side-buffer ejection stage: optionally diverts one valid flit per cycle
// into the side buffer and passes the remaining lanes through, one register stage.
module minbd_buff_eject #(
    parameter int unsigned FLIT_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    minbd_buff_eject_if.slave   bus
);
    localparam int unsigned N_LANES = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned VLD_BIT = FLIT_W - 1;

    // Lane indices match the productive-direction encoding of the flit header
    localparam logic [IDX_W-1:0] LANE_E = 2'd0;
    localparam logic [IDX_W-1:0] LANE_W = 2'd1;
    localparam logic [IDX_W-1:0] LANE_N = 2'd2;
    localparam logic [IDX_W-1:0] LANE_S = 2'd3;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_E    = 3'd1;
    localparam logic [2:0] SEL_W    = 3'd2;
    localparam logic [2:0] SEL_N    = 3'd3;
    localparam logic [2:0] SEL_S    = 3'd4;
    localparam logic [2:0] SEL_AUTO = 3'd5;

    logic [FLIT_W-1:0] lane_in_c [N_LANES];
    logic [FLIT_W-1:0] lane_d    [N_LANES];
    logic [FLIT_W-1:0] lane_q    [N_LANES];
    logic [FLIT_W-1:0] sbuff_d;
    logic [FLIT_W-1:0] sbuff_q;

    logic              cand_en_c;
    logic [IDX_W-1:0]  cand_idx_c;
    logic              eject_c;

    always_comb begin
        lane_in_c[LANE_E] = bus.eastad;
        lane_in_c[LANE_W] = bus.westad;
        lane_in_c[LANE_N] = bus.northad;
        lane_in_c[LANE_S] = bus.southad;
    end

    // Candidate decode; auto mode picks the first valid lane E > W > N > S
    always_comb begin
        cand_en_c  = 1'b0;
        cand_idx_c = LANE_E;
        case (bus.cthulhu)
            SEL_E: begin
                cand_en_c  = 1'b1;
                cand_idx_c = LANE_E;
            end
            SEL_W: begin
                cand_en_c  = 1'b1;
                cand_idx_c = LANE_W;
            end
            SEL_N: begin
                cand_en_c  = 1'b1;
                cand_idx_c = LANE_N;
            end
            SEL_S: begin
                cand_en_c  = 1'b1;
                cand_idx_c = LANE_S;
            end
            SEL_AUTO: begin
                cand_en_c = 1'b1;
                if (lane_in_c[LANE_E][VLD_BIT]) begin
                    cand_idx_c = LANE_E;
                end else if (lane_in_c[LANE_W][VLD_BIT]) begin
                    cand_idx_c = LANE_W;
                end else if (lane_in_c[LANE_N][VLD_BIT]) begin
                    cand_idx_c = LANE_N;
                end else begin
                    cand_idx_c = LANE_S;
                end
            end
            SEL_NONE: cand_en_c = 1'b0;
            default:  cand_en_c = 1'b0;
        endcase
    end

    assign eject_c = cand_en_c & lane_in_c[cand_idx_c][VLD_BIT];

    // Ejected lane is emptied; every other lane passes through positionally
    always_comb begin
        sbuff_d = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            lane_d[i] = lane_in_c[i];
        end
        if (eject_c) begin
            sbuff_d            = lane_in_c[cand_idx_c];
            lane_d[cand_idx_c] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                lane_q[i] <= '0;
            end
            sbuff_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
            sbuff_q <= sbuff_d;
        end
    end

    assign bus.ead   = lane_q[LANE_E];
    assign bus.wad   = lane_q[LANE_W];
    assign bus.nad   = lane_q[LANE_N];
    assign bus.sad   = lane_q[LANE_S];
    assign bus.sbuff = sbuff_q;

endmodule

// File: tb/tb_minbd_buff_eject.sv
// Directed bench for the MinBD side-buffer ejection stage, with a short random
// sweep checking flit conservation.
module tb_minbd_buff_eject;
    localparam int unsigned FLIT_W = 11;

    localparam logic [10:0] FE = 11'b100_1100_1100;
    localparam logic [10:0] FW = 11'b101_0000_0001;
    localparam logic [10:0] FN = 11'b110_0010_0010;
    localparam logic [10:0] FS = 11'b111_0011_0011;
    localparam logic [10:0] FW_INV = 11'b000_0001_1001;
    localparam logic [10:0] FE_INV = 11'b000_0101_0101;
    localparam logic [10:0] Z = 11'd0;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    minbd_buff_eject_if #(.FLIT_W(FLIT_W)) bus ();

    minbd_buff_eject #(.FLIT_W(FLIT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [10:0] e, input logic [10:0] w,
                         input logic [10:0] n, input logic [10:0] s);
        bus.cthulhu = c;
        bus.eastad  = e;
        bus.westad  = w;
        bus.northad = n;
        bus.southad = s;
    endtask

    task automatic check_all(input string tag, input logic [10:0] xe, input logic [10:0] xw,
                             input logic [10:0] xn, input logic [10:0] xs, input logic [10:0] xb);
        chk({tag, ".ead"},   bus.ead,   xe);
        chk({tag, ".wad"},   bus.wad,   xw);
        chk({tag, ".nad"},   bus.nad,   xn);
        chk({tag, ".sad"},   bus.sad,   xs);
        chk({tag, ".sbuff"}, bus.sbuff, xb);
    endtask

    // Drive away from the edge, capture on the next rising edge, check 1 time unit later
    task automatic run_vec(input string tag, input logic [2:0] c,
                           input logic [10:0] e, input logic [10:0] w,
                           input logic [10:0] n, input logic [10:0] s,
                           input logic [10:0] xe, input logic [10:0] xw,
                           input logic [10:0] xn, input logic [10:0] xs,
                           input logic [10:0] xb);
        @(negedge clk);
        drive(c, e, w, n, s);
        @(posedge clk);
        #1;
        check_all(tag, xe, xw, xn, xs, xb);
    endtask

    function automatic int vcount(input logic [10:0] a, input logic [10:0] b,
                                  input logic [10:0] c, input logic [10:0] d);
        return int'(a[10]) + int'(b[10]) + int'(c[10]) + int'(d[10]);
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(3'd1, FE, FW, FN, FS);

        // Held in reset with valid traffic present
        repeat (3) @(posedge clk);
        #1;
        check_all("rst_hold", Z, Z, Z, Z, Z);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_rel", Z, FW, FN, FS, FE);

        run_vec("ej_e", 3'd1, FE, FW, FN, FS, Z,  FW, FN, FS, FE);
        run_vec("ej_w", 3'd2, FE, FW, FN, FS, FE, Z,  FN, FS, FW);
        run_vec("ej_n", 3'd3, FE, FW, FN, FS, FE, FW, Z,  FS, FN);
        run_vec("ej_s", 3'd4, FE, FW, FN, FS, FE, FW, FN, Z,  FS);
        run_vec("inv_w", 3'd2, FE, FW_INV, FN, FS, FE, FW_INV, FN, FS, Z);
        run_vec("auto_w", 3'd5, FE_INV, FW, FN, FS, FE_INV, Z, FN, FS, FW);
        run_vec("auto_all", 3'd5, FE, FW, FN, FS, Z, FW, FN, FS, FE);
        run_vec("auto_s", 3'd5, Z, FW_INV, Z, FS, Z, FW_INV, Z, Z, FS);
        run_vec("auto_none", 3'd5, FE_INV, FW_INV, Z, Z, FE_INV, FW_INV, Z, Z, Z);
        run_vec("sel0", 3'd0, FE, FW, FN, FS, FE, FW, FN, FS, Z);
        run_vec("sel6", 3'd6, FE, FW, FN, FS, FE, FW, FN, FS, Z);
        run_vec("sel7", 3'd7, FE, FW, FN, FS, FE, FW, FN, FS, Z);

        // Asynchronous reset between edges drops the registered flit immediately
        run_vec("pre_mid", 3'd3, FE, FW, FN, FS, FE, FW, Z, FS, FN);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_mid", Z, Z, Z, Z, Z);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_mid", 3'd4, FE, FW, FN, FS, FE, FW, FN, Z, FS);

        // Random sweep: valid flits in == valid flits out (lanes + side buffer)
        for (int k = 0; k < 60; k++) begin
            logic [10:0] re, rw, rn, rs;
            logic [2:0]  rc;
            int          exp_cnt;
            int          got_cnt;
            re = 11'($urandom);
            rw = 11'($urandom);
            rn = 11'($urandom);
            rs = 11'($urandom);
            rc = 3'($urandom);
            exp_cnt = vcount(re, rw, rn, rs);
            @(negedge clk);
            drive(rc, re, rw, rn, rs);
            @(posedge clk);
            #1;
            got_cnt = vcount(bus.ead, bus.wad, bus.nad, bus.sad) + int'(bus.sbuff[10]);
            chk("conserve", 11'(got_cnt), 11'(exp_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
